// File: rtl/ring_phase_decoder.sv
// rtl/ring_phase_decoder.sv - one-hot ring phase decoder with lock tracking, rotation count and sticky errors
// Optional feature macro: RINGDEC_STALL_CHECK_EN (phase must hold while en=0 and locked)
module ring_phase_decoder #(
   parameter int N      = 4,
   parameter int IDX_W  = $clog2(N),
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [N-1:0]      phase,
   input  logic              clr_err,
   output logic [IDX_W-1:0]  idx,
   output logic              valid,
   output logic              onehot_err,
   output logic              seq_err,
   output logic [WRAP_W-1:0] wraps
);

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                valid_q, valid_d;
   logic                onehot_err_q, onehot_err_d;
   logic                seq_err_q, seq_err_d;
   logic [WRAP_W-1:0]   wraps_q, wraps_d;

   logic                phase_zero;
   logic                phase_onehot;
   logic [IDX_W-1:0]    phase_pos;
   logic [IDX_W-1:0]    succ_pos;
   logic                set_onehot_err;
   logic                set_seq_err;

   // Classify the sampled vector and encode the position of its set bit
   always_comb begin
      phase_zero   = ~|phase;
      phase_onehot = !phase_zero && ((phase & (phase - N'(1))) == '0);
      phase_pos    = '0;
      for (int i = 0; i < N; i++) begin
         if (phase[i]) begin
            phase_pos = IDX_W'(i);
         end
      end
      // Rotate-left successor: position N-1 is followed by position 0
      succ_pos = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
   end

   // Next-state and next-output computation for the acquire/track machine
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      valid_d        = valid_q;
      wraps_d        = wraps_q;
      set_onehot_err = 1'b0;
      set_seq_err    = 1'b0;

      if (en) begin
         case (state_q)
            ACQUIRE: begin
               if (phase_onehot) begin
                  idx_d   = phase_pos;
                  state_d = TRACK;
                  valid_d = 1'b1;
               end else if (!phase_zero) begin
                  set_onehot_err = 1'b1;
               end
            end
            TRACK: begin
               if (!phase_onehot) begin
                  // Illegal vector: drop lock but keep the last legal index visible
                  set_onehot_err = 1'b1;
                  state_d        = ACQUIRE;
                  valid_d        = 1'b0;
               end else if (phase_pos == succ_pos) begin
                  idx_d = phase_pos;
                  if (idx_q == IDX_W'(N - 1) && phase_pos == '0) begin
                     wraps_d = wraps_q + WRAP_W'(1);
                  end
               end else begin
                  // Legal but out of sequence: flag it and re-lock on the new phase
                  set_seq_err = 1'b1;
                  idx_d       = phase_pos;
               end
            end
            default: begin
               state_d = ACQUIRE;
               valid_d = 1'b0;
            end
         endcase
      end
`ifdef RINGDEC_STALL_CHECK_EN
      else if (state_q == TRACK) begin
         // While stalled the ring must still present the phase we locked on
         if (phase != (N'(1) << idx_q)) begin
            set_seq_err = 1'b1;
         end
      end
`endif

      // Sticky flags: a clear and a same-edge detection resolve to set
      onehot_err_d = (onehot_err_q & ~clr_err) | set_onehot_err;
      seq_err_d    = (seq_err_q & ~clr_err) | set_seq_err;
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ACQUIRE;
         idx_q        <= '0;
         valid_q      <= 1'b0;
         onehot_err_q <= 1'b0;
         seq_err_q    <= 1'b0;
         wraps_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         valid_q      <= valid_d;
         onehot_err_q <= onehot_err_d;
         seq_err_q    <= seq_err_d;
         wraps_q      <= wraps_d;
      end
   end

   assign idx        = idx_q;
   assign valid      = valid_q;
   assign onehot_err = onehot_err_q;
   assign seq_err    = seq_err_q;
   assign wraps      = wraps_q;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// tb/tb_ring_phase_decoder.sv - self-checking bench for ring_phase_decoder against a behavioural phase model
module tb_ring_phase_decoder;

   localparam int N      = 4;
   localparam int IDX_W  = 2;
   localparam int WRAP_W = 8;

   logic              clk;
   logic              reset_n;
   logic              en;
   logic [N-1:0]      phase;
   logic              clr_err;
   logic [IDX_W-1:0]  idx;
   logic              valid;
   logic              onehot_err;
   logic              seq_err;
   logic [WRAP_W-1:0] wraps;

   int n_checks;
   int n_fail;

   // behavioural model state
   bit m_locked;
   int m_idx;
   int m_wraps;
   bit m_oe;
   bit m_se;

   ring_phase_decoder #(.N(N), .IDX_W(IDX_W), .WRAP_W(WRAP_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .phase      (phase),
      .clr_err    (clr_err),
      .idx        (idx),
      .valid      (valid),
      .onehot_err (onehot_err),
      .seq_err    (seq_err),
      .wraps      (wraps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [IDX_W+WRAP_W+2:0] act_vec = {valid, idx, onehot_err, seq_err, wraps};

   function automatic logic [IDX_W+WRAP_W+2:0] exp_vec();
      logic [IDX_W-1:0]  ei;
      logic [WRAP_W-1:0] ew;
      ei = IDX_W'(m_idx);
      ew = WRAP_W'(m_wraps);
      return {m_locked, ei, m_oe, m_se, ew};
   endfunction

   function automatic int bit_pos(input logic [N-1:0] p);
      for (int i = 0; i < N; i++) if (p == (N'(1) << i)) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] hot(input int pos);
      return N'(1) << pos;
   endfunction

   // model of one clock edge, written from the decoder's rules
   task automatic model_edge(input bit r, input bit e, input logic [N-1:0] p, input bit c);
      bit so, ss;
      int pos;
      so = 0; ss = 0;
      if (!r) begin
         m_locked = 0; m_idx = 0; m_wraps = 0; m_oe = 0; m_se = 0;
      end else begin
         pos = bit_pos(p);
         if (e) begin
            if (!m_locked) begin
               if (pos >= 0) begin m_idx = pos; m_locked = 1; end
               else if (p != 0) so = 1;
            end else begin
               if (pos < 0) begin so = 1; m_locked = 0; end
               else if (pos == (m_idx + 1) % N) begin
                  if (m_idx == N - 1 && pos == 0) m_wraps = (m_wraps + 1) % (1 << WRAP_W);
                  m_idx = pos;
               end else begin
                  ss = 1; m_idx = pos;
               end
            end
         end
`ifdef RINGDEC_STALL_CHECK_EN
         else if (m_locked && p != hot(m_idx)) ss = 1;
`endif
         if (c) begin m_oe = 0; m_se = 0; end
         m_oe = m_oe | so;
         m_se = m_se | ss;
      end
   endtask

   // apply one cycle of inputs, advance the model, sample 1 ns after the edge
   task automatic cyc(input bit r, input bit e, input logic [N-1:0] p, input bit c);
      reset_n = r; en = e; phase = p; clr_err = c;
      @(posedge clk);
      model_edge(r, e, p, c);
      #1;
   endtask

   task automatic test_reset();
      cyc(0, 1, 4'b0001, 0);
      cyc(0, 0, 4'b0000, 0);
      n_checks++;
      if (act_vec !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0", act_vec);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int exp_i [5] = '{0, 1, 2, 3, 0};
      cyc(1, 1, 4'b0000, 0);
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rotation_idle_valid: got %b required 0", valid);
      end
      for (int k = 0; k < 5; k++) begin
         cyc(1, 1, seq[k], 0);
         n_checks++;
         if (valid !== 1'b1 || idx !== IDX_W'(exp_i[k]) || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rotation_step%0d: got %h required %h (idx %0d)", k, act_vec, exp_vec(), exp_i[k]);
         end
      end
      n_checks++;
      if (wraps !== 8'd1 || onehot_err !== 1'b0 || seq_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rotation_wraps: got wraps=%0d oe=%b se=%b required 1,0,0", wraps, onehot_err, seq_err);
      end
   endtask

   task automatic test_seq_err();
      cyc(1, 1, 4'b0010, 0);
      cyc(1, 1, 4'b1000, 0);
      n_checks++;
      if (seq_err !== 1'b1 || idx !== 2'd3 || valid !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL seq_err_jump: got %h required %h", act_vec, exp_vec());
      end
      cyc(1, 1, 4'b0001, 0);
      n_checks++;
      if (idx !== 2'd0 || wraps !== 8'd2 || seq_err !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL seq_err_wrap: got %h required %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_onehot_err();
      cyc(1, 1, 4'b0110, 0);
      n_checks++;
      if (onehot_err !== 1'b1 || valid !== 1'b0 || idx !== 2'd0 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL onehot_multi: got %h required %h", act_vec, exp_vec());
      end
      cyc(1, 1, 4'b0100, 0);
      n_checks++;
      if (valid !== 1'b1 || idx !== 2'd2 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL onehot_relock: got %h required %h", act_vec, exp_vec());
      end
      cyc(1, 0, 4'b0100, 1);
      n_checks++;
      if (onehot_err !== 1'b0 || seq_err !== 1'b0 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL clr_err: got %h required %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_wrap_rollover();
      logic [IDX_W+WRAP_W+2:0] snap;
      int pos;
      cyc(0, 0, 4'b0000, 0);
      cyc(1, 1, 4'b0001, 0);
      pos = 0;
      for (int s = 0; s < 256 * N; s++) begin
         pos = (pos + 1) % N;
         cyc(1, 1, hot(pos), 0);
         if (s == 511) begin
            snap = act_vec;
            for (int h = 0; h < 5; h++) begin
`ifdef RINGDEC_STALL_CHECK_EN
               cyc(1, 0, hot(pos), 0);
`else
               cyc(1, 0, 4'($urandom), 0);
`endif
               n_checks++;
               if (act_vec !== snap || act_vec !== exp_vec()) begin
                  n_fail++;
                  $display("FAIL stall_hold%0d: got %h required %h", h, act_vec, snap);
               end
            end
            phase = hot(pos);
         end
      end
      n_checks++;
      if (wraps !== 8'd0 || valid !== 1'b1 || onehot_err !== 1'b0 || seq_err !== 1'b0 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL wrap_rollover: got %h required %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 0, 4'b0000, 0);
      cyc(1, 1, 4'b0001, 0);
      for (int s = 1; s <= 5 * N; s++) cyc(1, 1, hot(s % N), 0);
      cyc(1, 1, 4'b0010, 0);
      cyc(1, 1, 4'b0010, 0);
      cyc(1, 1, 4'b0100, 0);
      n_checks++;
      if (idx !== 2'd2 || wraps !== 8'd5 || seq_err !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got %h required %h", act_vec, exp_vec());
      end
      cyc(0, 1, 4'b1000, 0);
      n_checks++;
      if (act_vec !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: got %h required 0", act_vec);
      end
      cyc(1, 1, 4'b0100, 0);
      n_checks++;
      if (valid !== 1'b1 || idx !== 2'd2 || wraps !== 8'd0 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_mid_reacquire: got %h required %h", act_vec, exp_vec());
      end
   endtask

`ifdef RINGDEC_STALL_CHECK_EN
   task automatic test_stall_check();
      cyc(0, 0, 4'b0000, 0);
      cyc(1, 1, 4'b0010, 0);
      cyc(1, 0, 4'b0100, 0);
      n_checks++;
      if (seq_err !== 1'b1 || idx !== 2'd1 || valid !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL stall_check_set: got %h required %h", act_vec, exp_vec());
      end
      cyc(1, 0, 4'b0100, 1);
      n_checks++;
      if (seq_err !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL stall_check_set_wins: got %h required %h", act_vec, exp_vec());
      end
      cyc(1, 0, 4'b0010, 1);
      n_checks++;
      if (seq_err !== 1'b0 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL stall_check_clear: got %h required %h", act_vec, exp_vec());
      end
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] p;
      bit r, e, c;
      int mode;
      cyc(0, 0, 4'b0000, 0);
      for (int k = 0; k < 800; k++) begin
         mode = $urandom_range(0, 9);
         if (mode < 6)      p = hot(m_locked ? (m_idx + 1) % N : $urandom_range(0, N - 1));
         else if (mode < 7) p = hot(m_locked ? m_idx : 0);
         else if (mode < 8) p = hot($urandom_range(0, N - 1));
         else if (mode < 9) p = '0;
         else               p = 4'($urandom);
         r = ($urandom_range(0, 99) >= 2);
         e = ($urandom_range(0, 99) < 80);
         c = ($urandom_range(0, 99) < 6);
         cyc(r, e, p, c);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %h required %h (r=%b en=%b ph=%b clr=%b)", k, act_vec, exp_vec(), r, e, p, c);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      en       = 1'b0;
      phase    = '0;
      clr_err  = 1'b0;
      test_reset();
      test_rotation();
      test_seq_err();
      test_onehot_err();
      test_wrap_rollover();
      test_reset_mid();
`ifdef RINGDEC_STALL_CHECK_EN
      test_stall_check();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_phase_decoder.md
Name: ring_phase_decoder

Overview:
- Receiving end of the one-hot ring-counter phase bus.
- Samples an N-bit one-hot phase vector on each enabled cycle and produces a registered binary index.
- Checks that the vector is legal one-hot and that it advances by exactly one rotation step per enabled cycle.
- Counts full rotations and raises sticky error flags; sits beside any ring-sequenced datapath as its phase monitor.

Parameters:
- N, 4, phase vector width; N >= 2.
- IDX_W, $clog2(N), width of the binary index output.
- WRAP_W, 8, width of the rotation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  sample strobe; the same enable that advances the ring.
- phase  in  N  one-hot phase from the ring counter; bit 0 follows bit N-1.
- clr_err  in  1  synchronous clear of the sticky error flags.
- idx  out  IDX_W  binary index of the last legal sampled phase.
- valid  out  1  high while locked (TRACK state).
- onehot_err  out  1  sticky: a sample was not one-hot.
- seq_err  out  1  sticky: a legal sample was not the expected successor.
- wraps  out  WRAP_W  count of bit N-1 -> bit 0 transitions seen while locked.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - idx=0, valid=0, onehot_err=0, seq_err=0, wraps=0.
  - State goes to ACQUIRE; reset overrides every other input.
- Sampling: inputs are evaluated only on edges where en=1. With en=0, all state and outputs hold.
- Latency: one cycle. idx, valid, flags and wraps reflect the phase sampled on the previous enabled edge.
- Expected successor of a sample p is the rotate-left {p[N-2:0], p[N-1]}, i.e. bit N-1 wraps to bit 0.
- State machine, ACQUIRE (valid=0):
  - phase all-zero: idle ring start-up; stay in ACQUIRE, no error.
  - phase one-hot: idx <= bit position, move to TRACK, valid <= 1. wraps is not incremented.
  - phase with two or more bits set: onehot_err <= 1, stay in ACQUIRE.
- State machine, TRACK (valid=1):
  - phase equals expected successor: idx <= new position.
    - If the previous idx was N-1 and the new idx is 0, wraps increments modulo 2^WRAP_W. Wrap-around from all-ones to 0 is silent.
  - phase one-hot but not the successor (including a repeat of the same phase): seq_err <= 1, idx <= new position. Stay in TRACK; the decoder re-locks on the new phase. wraps is not incremented.
  - phase zero or multi-hot: onehot_err <= 1, go to ACQUIRE, valid <= 0. idx holds its last legal value.
- clr_err=1 clears both sticky flags on that edge regardless of en.
  - If an error is detected on the same edge, the set wins and the flag reads 1.
  - clr_err does not affect state, idx or wraps.
- Reset mid-operation discards lock and counts. The first legal sample after reset is treated as a fresh acquire.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: RINGDEC_STALL_CHECK_EN.
- Defined:
  - On edges with en=0 and state TRACK, phase must equal the last sampled phase, since the ring must hold while disabled.
  - A mismatch sets seq_err; state, idx and wraps are unchanged.
  - In ACQUIRE, or while reset_n=0, the check is inactive.
- Undefined: phase is ignored entirely when en=0, and no stall check logic is synthesized.

Test Plan:
1. Reset, then en=1 with phase sequence 0000, 0001, 0010, 0100, 1000, 0001 (N=4) -> valid=0 after the 0000 sample. Then valid=1 with idx 0,1,2,3,0 on successive cycles; wraps=1; both error flags 0.
2. Locked at idx=1, apply phase 1000 with en=1 -> next cycle seq_err=1, idx=3, valid=1. Follow with 0001 -> idx=0, wraps incremented by 1, seq_err still 1.
3. Locked, apply phase 0110 -> onehot_err=1, valid=0, idx held. Then 0100 -> valid=1, idx=2. Then clr_err=1 -> both flags 0 on the following cycle.
4. Run 256 full rotations with WRAP_W=8 -> wraps returns to 0 with no flag set. Hold en=0 for 5 cycles mid-run while phase is changed -> no output change (macro undefined).
5. Assert reset_n=0 for one cycle while locked at idx=2 with wraps=5 and seq_err=1 -> all outputs 0 the next cycle. A following sample of 0100 -> valid=1, idx=2, wraps=0.
6. With RINGDEC_STALL_CHECK_EN defined, locked at 0010 with en=0, drive phase 0100 -> seq_err=1, idx stays 1. With clr_err=1 and a simultaneous seq error, seq_err reads 1.
